// File: rtl/checkdigit_pkg.sv
// Shared types and constants for the check-digit engine.
// CHECKDIGIT_WEIGHT3_EN enables the weight-3 datapath.
package checkdigit_pkg;

  localparam logic [4:0] RADIX = 5'd10;

  typedef enum logic [1:0] {
    MODE_LUHN_GEN = 2'd0,
    MODE_LUHN_VER = 2'd1,
    MODE_W3_GEN   = 2'd2,
    MODE_W3_VER   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [3:0] mod10_add(
    input logic [3:0] a,
    input logic [3:0] b
  );
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= RADIX) s = s - RADIX;
    return s[3:0];
  endfunction

endpackage

// File: rtl/cd_weight.sv
// Digit weighting: Luhn doubling or weight-3, reduced modulo 10.
// Weight-3 path exists only with CHECKDIGIT_WEIGHT3_EN.
module cd_weight
  import checkdigit_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic       i_odd,
  input  logic       i_w3,
  output logic [3:0] o_wd
);

  logic [4:0] w_x2;
  logic [3:0] w_luhn;
  logic [3:0] w_sel;
  logic       w_valid;

  assign w_valid = (i_digit <= 4'd9);
  assign w_x2    = {i_digit, 1'b0};

  always_comb begin
    w_luhn = w_x2[3:0];
    if (w_x2 > 5'd9) w_luhn = 4'(w_x2 - 5'd9);
  end

`ifdef CHECKDIGIT_WEIGHT3_EN
  logic [4:0] w_x3;
  logic [3:0] w_w3v;

  assign w_x3 = {1'b0, i_digit} + {i_digit, 1'b0};

  always_comb begin
    w_w3v = w_x3[3:0];
    unique case (1'b1)
      (w_x3 >= 5'd20):
        w_w3v = 4'(w_x3 - 5'd20);
      (w_x3 >= 5'd10 && w_x3 < 5'd20):
        w_w3v = 4'(w_x3 - 5'd10);
      default: ;
    endcase
  end

  always_comb begin
    w_sel = i_digit;
    if (i_odd) w_sel = i_w3 ? w_w3v : w_luhn;
  end
`else
  logic w_unused_w3;
  assign w_unused_w3 = i_w3;

  always_comb begin
    w_sel = i_digit;
    if (i_odd) w_sel = w_luhn;
  end
`endif

  // Non-BCD digits contribute nothing; the engine flags them.
  assign o_wd = w_valid ? w_sel : 4'd0;

endmodule

// File: rtl/checkdigit_engine.sv
// Streaming Luhn / weight-3 check-digit generator and verifier.
// Weight-3 modes need CHECKDIGIT_WEIGHT3_EN, else they fall back to Luhn.
module checkdigit_engine
  import checkdigit_pkg::*;
#(
  parameter int N_DIGITS = 15,
  parameter int CNT_W    = $clog2(N_DIGITS + 2)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [3:0] in_num,
  input  logic [1:0] in_mode,
  output logic       in_ready,
  output logic       out_valid,
  output logic [3:0] out,
  output logic       out_ok,
  output logic       out_err
);

  localparam logic P_NODD = ((N_DIGITS % 2) == 1);

  state_e           r_state;
  state_e           w_state_nx;
  mode_e            r_mode;
  logic [3:0]       r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_live;

  mode_e            w_mode;
  logic [CNT_W-1:0] w_len;
  logic             w_take;
  logic             w_last;
  logic             w_odd;
  logic             w_w3;
  logic             w_mode_err;
  logic             w_bad;
  logic [3:0]       w_wd;
  logic [3:0]       w_sum;

  assign in_ready = r_live && (r_state != DONE);
  assign w_take   = in_valid && in_ready;
  assign w_mode   = (r_state == IDLE) ? mode_e'(in_mode) : r_mode;
  assign w_len    = CNT_W'(N_DIGITS) + CNT_W'(w_mode[0]);
  assign w_last   = ((r_cnt + CNT_W'(1)) == w_len);
  assign w_bad    = (in_num > 4'd9);

  // Distance to check position is N_DIGITS - r_cnt; only its parity matters.
  assign w_odd = P_NODD ^ r_cnt[0];

`ifdef CHECKDIGIT_WEIGHT3_EN
  assign w_w3       = w_mode[1];
  assign w_mode_err = 1'b0;
`else
  assign w_w3       = 1'b0;
  assign w_mode_err = w_mode[1];
`endif

  cd_weight u_weight (
    .i_digit (in_num),
    .i_odd   (w_odd),
    .i_w3    (w_w3),
    .o_wd    (w_wd)
  );

  assign w_sum = mod10_add(r_acc, w_wd);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      IDLE:    if (w_take) w_state_nx = w_last ? DONE : ACC;
      ACC:     if (w_take && w_last) w_state_nx = DONE;
      DONE:    w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live <= 1'b0;
      r_mode <= MODE_LUHN_GEN;
      r_acc  <= 4'd0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (r_state == DONE) begin
        r_acc <= 4'd0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_take) begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
        r_err <= r_err | w_bad | w_mode_err;
        if (r_state == IDLE) r_mode <= mode_e'(in_mode);
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out       = 4'd0;
    out_ok    = 1'b0;
    out_err   = 1'b0;
    if (r_state == DONE) begin
      out_valid = 1'b1;
      out_err   = r_err;
      if (r_mode[0])
        out_ok = (r_acc == 4'd0);
      else if (r_acc != 4'd0)
        out = 4'(RADIX - {1'b0, r_acc});
    end
  end

endmodule

// File: tb/tb_checkdigit_engine.sv
// Randomised self-checking bench for checkdigit_engine.
// Three instances (N_DIGITS 10, 12, 15) against a behavioural model.
`timescale 1ns/1ps
module tb_checkdigit_engine;

  logic       clk;
  logic       rst_n;
  logic       vld  [3];
  logic [3:0] num  [3];
  logic [1:0] mode [3];
  logic       rdy  [3];
  logic       ov   [3];
  logic [3:0] o    [3];
  logic       ok   [3];
  logic       er   [3];

  int nds [3] = '{10, 12, 15};
  int checks;
  int failures;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ND = (g == 0) ? 10 : ((g == 1) ? 12 : 15);
    checkdigit_engine #(.N_DIGITS(ND)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (vld[g]),
      .in_num    (num[g]),
      .in_mode   (mode[g]),
      .in_ready  (rdy[g]),
      .out_valid (ov[g]),
      .out       (o[g]),
      .out_ok    (ok[g]),
      .out_err   (er[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: sum weighted digits by distance from the check position.
  function automatic void model(
    input  int n,
    input  int m,
    input  int dq[$],
    output int eo,
    output int eok,
    output int eerr
  );
    int s;
    bit w3;
    s    = 0;
    eerr = 0;
    w3   = (m >= 2);
`ifndef CHECKDIGIT_WEIGHT3_EN
    if (w3) begin
      w3   = 0;
      eerr = 1;
    end
`endif
    foreach (dq[i]) begin
      int d;
      int x;
      int w;
      d = n - i;
      x = dq[i];
      if (x > 9) begin
        eerr = 1;
        w    = 0;
      end else if (d % 2 == 1) begin
        if (w3) w = (3 * x) % 10;
        else    w = (2 * x > 9) ? 2 * x - 9 : 2 * x;
      end else begin
        w = x;
      end
      s += w;
    end
    s   = s % 10;
    eo  = (m % 2 == 0) ? (10 - s) % 10 : 0;
    eok = (m % 2 == 1) ? ((s == 0) ? 1 : 0) : 0;
  endfunction

  // Entered and left on a falling edge; returns while the DUT is in DONE.
  task automatic run_frame(
    input int    k,
    input int    m,
    input int    dq[$],
    input int    gap_pct,
    input int    eo,
    input int    eok,
    input int    eerr,
    input string nm
  );
    int i;
    int cyc;
    bit r;
    i   = 0;
    cyc = 0;
    while (i < dq.size() && cyc < 500) begin
      cyc++;
      if ($urandom_range(99) < gap_pct) begin
        vld[k] = 1'b0;
        num[k] = 4'($urandom);
      end else begin
        vld[k] = 1'b1;
        num[k] = 4'(dq[i]);
      end
      mode[k] = (i == 0) ? 2'(m) : 2'($urandom);
      r = rdy[k];
      if (r) begin
        checks++;
        if (ov[k] !== 1'b0 || o[k] !== 4'd0 ||
            ok[k] !== 1'b0 || er[k] !== 1'b0) begin
          failures++;
          $display("FAIL %s quiet_outputs k=%0d got v=%b o=%0d ok=%b e=%b want 0",
                   nm, k, ov[k], o[k], ok[k], er[k]);
        end
      end
      @(posedge clk);
      if (vld[k] && r) i++;
      @(negedge clk);
    end
    vld[k] = 1'b0;
    checks++;
    if (i < dq.size()) begin
      failures++;
      $display("FAIL %s timeout k=%0d accepted %0d want %0d", nm, k, i, dq.size());
    end else if (ov[k] !== 1'b1 || o[k] !== 4'(eo) || ok[k] !== 1'(eok) ||
                 er[k] !== 1'(eerr) || rdy[k] !== 1'b0) begin
      failures++;
      $display("FAIL %s result k=%0d got v=%b o=%0d ok=%b e=%b rdy=%b want v=1 o=%0d ok=%0d e=%0d rdy=0",
               nm, k, ov[k], o[k], ok[k], er[k], rdy[k], eo, eok, eerr);
    end
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (ov[k] !== 1'b0 || o[k] !== 4'd0 || ok[k] !== 1'b0 || er[k] !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs k=%0d got v=%b o=%0d ok=%b e=%b want 0",
                   k, ov[k], o[k], ok[k], er[k]);
        end
      end
    end
  endtask

  task automatic rand_frame(input int k, input int m, output int dq[$]);
    dq = {};
    for (int i = 0; i < nds[k] + (m % 2); i++) begin
      if ($urandom_range(99) < 5) dq.push_back(int'($urandom_range(15, 10)));
      else                        dq.push_back(int'($urandom_range(9)));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      vld[k]  = 1'b0;
      num[k]  = 4'd0;
      mode[k] = 2'd0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b0 || ov[k] !== 1'b0 || o[k] !== 4'd0 ||
          ok[k] !== 1'b0 || er[k] !== 1'b0) begin
        failures++;
        $display("FAIL reset_outputs k=%0d got rdy=%b v=%b o=%0d ok=%b e=%b want 0",
                 k, rdy[k], ov[k], o[k], ok[k], er[k]);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (rdy[0] !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_before_clk got %b want 0", rdy[0]);
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rdy[k] !== 1'b1) begin
        failures++;
        $display("FAIL reset_rdy_after_clk k=%0d got %b want 1", k, rdy[k]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_luhn_gen();
    int q[$];
    q = {7, 9, 9, 2, 7, 3, 9, 8, 7, 1};
    run_frame(0, 0, q, 0, 3, 0, 0, "luhn_gen");
    idle(1);
  endtask

  task automatic test_luhn_ver();
    int q[$];
    q = {7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 3};
    run_frame(0, 1, q, 0, 0, 1, 0, "luhn_ver_good");
    q = {7, 9, 9, 2, 7, 3, 9, 8, 7, 1, 0};
    run_frame(0, 1, q, 0, 0, 0, 0, "luhn_ver_bad");
    idle(1);
  endtask

  task automatic test_weight3();
    int q[$];
    int eo, eok, ee;
    q = {4, 0, 0, 6, 3, 8, 1, 3, 3, 3, 9, 3};
`ifdef CHECKDIGIT_WEIGHT3_EN
    eo = 1; eok = 0; ee = 0;
`else
    model(12, 2, q, eo, eok, ee);
`endif
    run_frame(1, 2, q, 30, eo, eok, ee, "w3_gen");
    idle(1);
    q.push_back(1);
`ifdef CHECKDIGIT_WEIGHT3_EN
    eo = 0; eok = 1; ee = 0;
`else
    model(12, 3, q, eo, eok, ee);
`endif
    run_frame(1, 3, q, 30, eo, eok, ee, "w3_ver");
    idle(1);
  endtask

  task automatic test_back_to_back();
    int q[$];
    int eo, eok, ee, m;
    q = {};
    for (int i = 0; i < 15; i++) q.push_back(0);
    run_frame(2, 0, q, 0, 0, 0, 0, "zeros");
    for (int f = 0; f < 2; f++) begin
      m = $urandom_range(1);
      rand_frame(2, m, q);
      model(15, m, q, eo, eok, ee);
      run_frame(2, m, q, 0, eo, eok, ee, "back_to_back");
    end
    idle(1);
  endtask

  task automatic test_bad_digit();
    int q[$];
    int eo, eok, ee;
    q = {1, 2, 12, 4, 5, 6, 7, 8, 9, 0};
    model(10, 0, q, eo, eok, ee);
    run_frame(0, 0, q, 10, eo, eok, 1, "bad_digit");
    idle(1);
  endtask

  task automatic test_reset_midframe();
    int q[$];
    int eo, eok, ee;
    for (int i = 0; i < 5; i++) begin
      vld[0]  = 1'b1;
      num[0]  = 4'($urandom_range(9));
      mode[0] = 2'd0;
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (rdy[0] !== 1'b0 || ov[0] !== 1'b0) begin
      failures++;
      $display("FAIL midframe_reset got rdy=%b v=%b want 0 0", rdy[0], ov[0]);
    end
    vld[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rand_frame(0, 0, q);
    model(10, 0, q, eo, eok, ee);
    run_frame(0, 0, q, 20, eo, eok, ee, "after_reset");
    idle(1);
  endtask

  task automatic test_random();
    int q[$];
    int eo, eok, ee, k, m;
    for (int f = 0; f < 30; f++) begin
      k = $urandom_range(2);
      m = $urandom_range(3);
      rand_frame(k, m, q);
      model(nds[k], m, q, eo, eok, ee);
      run_frame(k, m, q, 25, eo, eok, ee, "random");
      if ($urandom_range(1) == 1) idle(1);
    end
    idle(1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_luhn_gen();
    test_luhn_ver();
    test_weight3();
    test_back_to_back();
    test_bad_digit();
    test_reset_midframe();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
